// File: rtl/axi_arb_pkg.sv
// Shared types and default widths for the AXI address-channel arbiters.
package axi_arb_pkg;

  localparam int unsigned DEF_NUM_M     = 2;
  localparam int unsigned DEF_ID_BITS   = 4;
  localparam int unsigned DEF_ADDR_BITS = 32;
  localparam int unsigned DEF_LEN_BITS  = 4;
  localparam int unsigned DEF_SIZE_BITS = 3;
  localparam int unsigned DEF_MIDX_BITS = 4;
  localparam int unsigned CNT_BITS      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Width of a pointer/index addressing n masters (never narrower than 1 bit).
  function automatic int unsigned rr_ptr_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping mod N.
import axi_arb_pkg::*;

module axi_rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int unsigned j;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        idx       = PW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_ar_rr_arbiter.sv
// N-master AXI AR channel arbiter, round-robin with a handshake-locked registered grant.
// Optional per-master handshake counters on GRANT_CNT when AXI_AR_ARB_PERF_CNT_EN is defined.
import axi_arb_pkg::*;

module axi_ar_rr_arbiter #(
  parameter int unsigned NUM_M     = DEF_NUM_M,
  parameter int unsigned ID_BITS   = DEF_ID_BITS,
  parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
  parameter int unsigned LEN_BITS  = DEF_LEN_BITS,
  parameter int unsigned SIZE_BITS = DEF_SIZE_BITS,
  parameter int unsigned MIDX_BITS = DEF_MIDX_BITS
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
`ifdef AXI_AR_ARB_PERF_CNT_EN
  output logic [NUM_M*CNT_BITS-1:0]      GRANT_CNT,
`endif
  input  logic [NUM_M*ID_BITS-1:0]       ARID_M,
  input  logic [NUM_M*ADDR_BITS-1:0]     ARADDR_M,
  input  logic [NUM_M*LEN_BITS-1:0]      ARLEN_M,
  input  logic [NUM_M*SIZE_BITS-1:0]     ARSIZE_M,
  input  logic [NUM_M*2-1:0]             ARBURST_M,
  input  logic [NUM_M-1:0]               ARVALID_M,
  output logic [NUM_M-1:0]               ARREADY_M,
  output logic [MIDX_BITS+ID_BITS-1:0]   ARID_S,
  output logic [ADDR_BITS-1:0]           ARADDR_S,
  output logic [LEN_BITS-1:0]            ARLEN_S,
  output logic [SIZE_BITS-1:0]           ARSIZE_S,
  output logic [1:0]                     ARBURST_S,
  output logic                           ARVALID_S,
  input  logic                           ARREADY_S
);

  localparam int unsigned PW = rr_ptr_bits(NUM_M);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [NUM_M-1:0]  grant_oh_q, grant_oh_d;

  logic [NUM_M-1:0]  pick_oh;
  logic [PW-1:0]     pick_idx;
  logic              pick_found;
  logic              busy;
  logic              granted_valid;
  logic              hs;

  axi_rr_picker #(
    .N  (NUM_M),
    .PW (PW)
  ) u_picker (
    .req    (ARVALID_M),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign busy          = (state_q == BUSY);
  assign granted_valid = |(ARVALID_M & grant_oh_q);
  assign hs            = busy && granted_valid && ARREADY_S;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
    end
  end

  // Next state: grant held through BUSY until handshake or the granted master withdraws.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          grant_oh_d = pick_oh;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (!granted_valid) begin
          state_d = IDLE;
        end else if (ARREADY_S) begin
          rr_ptr_d = (grant_q == PW'(NUM_M - 1)) ? '0 : grant_q + PW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream payload is muxed live from the granted master; everything reads 0 outside BUSY.
  always_comb begin
    logic [ID_BITS-1:0] id_sel;
    id_sel    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (busy && grant_oh_q[i]) begin
        id_sel    = ARID_M[i*ID_BITS +: ID_BITS];
        ARADDR_S  = ARADDR_M[i*ADDR_BITS +: ADDR_BITS];
        ARLEN_S   = ARLEN_M[i*LEN_BITS +: LEN_BITS];
        ARSIZE_S  = ARSIZE_M[i*SIZE_BITS +: SIZE_BITS];
        ARBURST_S = ARBURST_M[i*2 +: 2];
      end
    end
    ARID_S    = busy ? {MIDX_BITS'(grant_q), id_sel} : '0;
    ARVALID_S = busy && granted_valid;
    ARREADY_M = busy ? (grant_oh_q & {NUM_M{ARREADY_S}}) : '0;
  end

`ifdef AXI_AR_ARB_PERF_CNT_EN
  logic [NUM_M*CNT_BITS-1:0] cnt_q;

  // Saturating count of completed handshakes per master.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_M; i++) begin
        if (hs && grant_oh_q[i] && (cnt_q[i*CNT_BITS +: CNT_BITS] != {CNT_BITS{1'b1}}))
          cnt_q[i*CNT_BITS +: CNT_BITS] <= cnt_q[i*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
      end
    end
  end

  assign GRANT_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_axi_ar_rr_arbiter.sv
// Directed bench for axi_ar_rr_arbiter: scoreboard of expected AR handshakes plus cycle checks.
module tb_axi_ar_rr_arbiter;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  logic        ARESETn;

  // 2-master instance
  logic [7:0]  arid_m;
  logic [63:0] araddr_m;
  logic [7:0]  arlen_m;
  logic [5:0]  arsize_m;
  logic [3:0]  arburst_m;
  logic [1:0]  arvalid_m;
  logic [1:0]  arready_m;
  logic [7:0]  arid_s;
  logic [31:0] araddr_s;
  logic [3:0]  arlen_s;
  logic [2:0]  arsize_s;
  logic [1:0]  arburst_s;
  logic        arvalid_s;
  logic        arready_s;

  // 4-master instance, all masters always requesting
  logic [15:0]  arid4_m;
  logic [127:0] araddr4_m;
  logic [15:0]  arlen4_m;
  logic [11:0]  arsize4_m;
  logic [7:0]   arburst4_m;
  logic [3:0]   arvalid4_m;
  logic [3:0]   arready4_m;
  logic [7:0]   arid4_s;
  logic [31:0]  araddr4_s;
  logic [3:0]   arlen4_s;
  logic [2:0]   arsize4_s;
  logic [1:0]   arburst4_s;
  logic         arvalid4_s;
  logic         arready4_s;

`ifdef AXI_AR_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt;
  logic [63:0] grant_cnt4;
`endif

  axi_ar_rr_arbiter dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
`ifdef AXI_AR_ARB_PERF_CNT_EN
    .GRANT_CNT (grant_cnt),
`endif
    .ARID_M    (arid_m),
    .ARADDR_M  (araddr_m),
    .ARLEN_M   (arlen_m),
    .ARSIZE_M  (arsize_m),
    .ARBURST_M (arburst_m),
    .ARVALID_M (arvalid_m),
    .ARREADY_M (arready_m),
    .ARID_S    (arid_s),
    .ARADDR_S  (araddr_s),
    .ARLEN_S   (arlen_s),
    .ARSIZE_S  (arsize_s),
    .ARBURST_S (arburst_s),
    .ARVALID_S (arvalid_s),
    .ARREADY_S (arready_s)
  );

  axi_ar_rr_arbiter #(.NUM_M(4)) dut4 (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
`ifdef AXI_AR_ARB_PERF_CNT_EN
    .GRANT_CNT (grant_cnt4),
`endif
    .ARID_M    (arid4_m),
    .ARADDR_M  (araddr4_m),
    .ARLEN_M   (arlen4_m),
    .ARSIZE_M  (arsize4_m),
    .ARBURST_M (arburst4_m),
    .ARVALID_M (arvalid4_m),
    .ARREADY_M (arready4_m),
    .ARID_S    (arid4_s),
    .ARADDR_S  (araddr4_s),
    .ARLEN_S   (arlen4_s),
    .ARSIZE_S  (arsize4_s),
    .ARBURST_S (arburst4_s),
    .ARVALID_S (arvalid4_s),
    .ARREADY_S (arready4_s)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [1:0]  rdy;
  } exp_t;

  exp_t        sbq[$];
  int unsigned got4[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected downstream view of master m's (fixed) request.
  task automatic push_exp(input int m);
    exp_t e;
    if (m == 0) begin
      e.id = 8'h0A; e.addr = 32'h1000_0000; e.rdy = 2'b01;
    end else begin
      e.id = 8'h13; e.addr = 32'h0001_0040; e.rdy = 2'b10;
    end
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard: every handshake must match the next expected grant.
  always @(negedge ACLK) begin
    if (arvalid_s && arready_s) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_hs", 64'(arid_s), 64'hFFFF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_id", 64'(arid_s), 64'(e.id));
        chk("sb_addr", 64'(araddr_s), 64'(e.addr));
        chk("sb_ready", 64'(arready_m), 64'(e.rdy));
      end
    end
    if (arvalid4_s && arready4_s)
      got4.push_back(int'(arid4_s[7:4]));
  end

  initial begin
    ARESETn    = 1'b0;
    arid_m     = {4'h3, 4'hA};
    araddr_m   = {32'h0001_0040, 32'h1000_0000};
    arlen_m    = {4'h2, 4'h7};
    arsize_m   = {3'd3, 3'd2};
    arburst_m  = {2'b10, 2'b01};
    arvalid_m  = 2'b11;
    arready_s  = 1'b0;
    arid4_m    = 16'h3210;
    araddr4_m  = {32'h4000_0300, 32'h4000_0200, 32'h4000_0100, 32'h4000_0000};
    arlen4_m   = '0;
    arsize4_m  = '0;
    arburst4_m = '0;
    arvalid4_m = 4'hF;
    arready4_s = 1'b1;

    // Reset held with both masters requesting
    repeat (3) tick();
    chk("rst_arvalid_s", 64'(arvalid_s), 64'h0);
    chk("rst_arready_m", 64'(arready_m), 64'h0);
    chk("rst_arid_s", 64'(arid_s), 64'h0);
    chk("rst_araddr_s", 64'(araddr_s), 64'h0);

    // Release: M0 wins from rr_ptr=0, then 5 cycles of backpressure with M1 waiting
    ARESETn = 1'b1;
    tick();
    chk("first_grant_valid", 64'(arvalid_s), 64'h1);
    chk("first_grant_id", 64'(arid_s), 64'h0A);
    push_exp(0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(arvalid_s), 64'h1);
      chk("bp_id", 64'(arid_s), 64'h0A);
      chk("bp_addr", 64'(araddr_s), 64'h1000_0000);
      chk("bp_ready_m", 64'(arready_m), 64'h0);
    end
    arready_s = 1'b1;
    #1;
    chk("bp_release_ready_m", 64'(arready_m), 64'h1);
    tick();
    chk("post_hs_idle", 64'(arvalid_s), 64'h0);

    // Continuous requests, always ready: rr_ptr now 1 -> M1,M0,M1,M0
    push_exp(1); push_exp(0); push_exp(1); push_exp(0);
    repeat (8) tick();
    arvalid_m = 2'b00;
    arready_s = 1'b0;
    #1;
    chk("rr_drain", 64'(sbq.size()), 64'h0);

    // Single M1 request
    arvalid_m = 2'b10;
    tick();
    chk("m1_valid", 64'(arvalid_s), 64'h1);
    chk("m1_id", 64'(arid_s), 64'h13);
    chk("m1_addr", 64'(araddr_s), 64'h0001_0040);
    chk("m1_len", 64'(arlen_s), 64'h2);
    chk("m1_size", 64'(arsize_s), 64'h3);
    chk("m1_burst", 64'(arburst_s), 64'h2);
    push_exp(1);
    arready_s = 1'b1;
    #1;
    chk("m1_ready_m", 64'(arready_m), 64'h2);
    tick();
    chk("m1_idle_valid", 64'(arvalid_s), 64'h0);
    chk("m1_idle_ready_m", 64'(arready_m), 64'h0);

    // ARREADY_S alone in IDLE does nothing
    arvalid_m = 2'b00;
    repeat (2) tick();
    chk("idle_ready_valid", 64'(arvalid_s), 64'h0);
    chk("idle_ready_ready_m", 64'(arready_m), 64'h0);
    arready_s = 1'b0;

    // Granted M0 withdraws mid-BUSY; rr_ptr must stay 0 so M0 wins again
    arvalid_m = 2'b01;
    tick();
    chk("drop_granted", 64'(arid_s), 64'h0A);
    arvalid_m = 2'b10;
    #1;
    chk("drop_valid_falls", 64'(arvalid_s), 64'h0);
    tick();
    chk("drop_idle", 64'(arvalid_s), 64'h0);
    arvalid_m = 2'b11;
    tick();
    chk("drop_regrant_id", 64'(arid_s), 64'h0A);
    push_exp(0);
    arready_s = 1'b1;
    tick();
    arvalid_m = 2'b00;
    arready_s = 1'b0;

    // Reset during BUSY with rr_ptr=1: abandoned, and pointer returns to 0
    arvalid_m = 2'b10;
    tick();
    chk("rstbusy_granted", 64'(arid_s), 64'h13);
    ARESETn = 1'b0;
    tick();
    chk("rstbusy_valid", 64'(arvalid_s), 64'h0);
    chk("rstbusy_id", 64'(arid_s), 64'h0);
    ARESETn = 1'b1;
    arvalid_m = 2'b11;
    tick();
    chk("rstbusy_ptr0_id", 64'(arid_s), 64'h0A);
    push_exp(0);
    arready_s = 1'b1;
    tick();
    arvalid_m = 2'b00;
    arready_s = 1'b0;
    tick();
    chk("final_drain", 64'(sbq.size()), 64'h0);

`ifdef AXI_AR_ARB_PERF_CNT_EN
    chk("cnt_m0", 64'(grant_cnt[15:0]), 64'h1);
    chk("cnt_m1", 64'(grant_cnt[31:16]), 64'h0);
`endif

    // 4-master rotation recorded since the first reset release
    chk("rr4_count", 64'(got4.size() >= 5), 64'h1);
    for (int k = 0; k < 5; k++) begin
      if (k < got4.size())
        chk("rr4_order", 64'(got4[k]), 64'(k % 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
